cordiv_sng: RTL and testbench

Correlated stochastic number generator that produces the paired dividend and divisor bitstreams consumed by the CORDIV stochastic divider. It converts two WIDTH-bit binary operands into two unipolar bitstreams of length 2^WIDTH. Both streams are compared against one shared random source, so they are maximally positively correlated. This is the property CORDIV relies on for an accurate quotient. The block sits between the binary operand registers and the stochastic compute units.

---
 rtl/cordiv_sng_if.sv | 32 +++
 rtl/cordiv_sng.sv | 153 +++++++++++++++
 tb/tb_cordiv_sng.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordiv_sng_if.sv
// Operand/stream bundle for the CORDIV correlated stochastic number generator.
//
// Handshake: start is a request level that the generator samples only while
// idle; busy is the acknowledge and stays high for the whole run. bs_valid
// qualifies dividend_bs/divisor_bs for exactly one cycle per stream bit with
// no backpressure (the consumer must take every valid bit), and done marks
// the cycle that carries the final bit of the run.
interface cordiv_sng_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] dividend_bin;
  logic [WIDTH-1:0] divisor_bin;
  logic             busy;
  logic             bs_valid;
  logic             dividend_bs;
  logic             divisor_bs;
  logic             done;

  // Operand source side: requests runs and consumes the streams.
  modport master (
    output start, mode, dividend_bin, divisor_bin,
    input  busy, bs_valid, dividend_bs, divisor_bs, done
  );

  // Generator side.
  modport slave (
    input  start, mode, dividend_bin, divisor_bin,
    output busy, bs_valid, dividend_bs, divisor_bs, done
  );
endinterface

// File: rtl/cordiv_sng.sv
// Correlated stochastic number generator feeding the CORDIV divider.
// Both operands are compared against one shared random value per cycle, so
// the two unipolar streams are maximally positively correlated. The random
// source is either a bit-reversed counter (exact ones count) or a maximal
// length Fibonacci LFSR. Every output comes straight from a flop.
module cordiv_sng #(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic         clk,
  input  logic         rst,
  cordiv_sng_if.slave  bus,
  output logic [1:0]   dbg_state_o
);

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  // Feedback taps as 8-bit masks, trimmed to WIDTH bits.
  localparam logic [7:0] TAP8 = (WIDTH == 4) ? 8'h0C :
                                (WIDTH == 5) ? 8'h14 :
                                (WIDTH == 6) ? 8'h30 :
                                (WIDTH == 7) ? 8'h60 : 8'hB8;
  localparam logic [WIDTH-1:0] TAPS = TAP8[WIDTH-1:0];

  generate
    if (WIDTH < 4 || WIDTH > 8) begin : g_bad_width
      $error("cordiv_sng: WIDTH must be in 4..8");
    end
    if (SEED_V == '0) begin : g_bad_seed
      $error("cordiv_sng: SEED must be nonzero in its low WIDTH bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             dividend_bs_q, dividend_bs_d;
  logic             divisor_bs_q, divisor_bs_d;

  logic [WIDTH-1:0] bitrev_w;
  logic [WIDTH-1:0] lfsr_step_w;
  logic [WIDTH-1:0] rand_w;
  logic             last_bit_w;

  // Bit-reversed low WIDTH bits of the counter: spreads the thresholds so
  // the exact ones count is reached with well-mixed stream positions.
  always_comb begin
    bitrev_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bitrev_w[i] = cnt_q[WIDTH-1-i];
    end
  end

  assign lfsr_step_w = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign rand_w      = mode_q ? lfsr_q : bitrev_w;
  assign last_bit_w  = (cnt_q[WIDTH-1:0] == '1);

  // Next-state and registered-output logic. The bit issued at the edge that
  // leaves LOAD is stream bit 0, so LOAD and RUN share the issue path; RUN
  // stays one extra cycle after the last bit (cnt MSB set) to drop busy.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    dividend_d    = dividend_q;
    divisor_d     = divisor_q;
    mode_d        = mode_q;
    busy_d        = 1'b0;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    dividend_bs_d = 1'b0;
    divisor_bs_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD;
          dividend_d = bus.dividend_bin;
          divisor_d  = bus.divisor_bin;
          mode_d     = bus.mode;
          cnt_d      = '0;
          lfsr_d     = SEED_V;
          busy_d     = 1'b1;
        end
      end
      S_LOAD, S_RUN: begin
        if (state_q == S_RUN && cnt_q[WIDTH]) begin
          state_d = S_IDLE;
        end else begin
          state_d       = S_RUN;
          busy_d        = 1'b1;
          valid_d       = 1'b1;
          dividend_bs_d = (dividend_q > rand_w);
          divisor_bs_d  = (divisor_q > rand_w);
          done_d        = last_bit_w;
          cnt_d         = cnt_q + (WIDTH+1)'(1);
          lfsr_d        = lfsr_step_w;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      lfsr_q        <= SEED_V;
      dividend_q    <= '0;
      divisor_q     <= '0;
      mode_q        <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      dividend_bs_q <= 1'b0;
      divisor_bs_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      dividend_q    <= dividend_d;
      divisor_q     <= divisor_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      dividend_bs_q <= dividend_bs_d;
      divisor_bs_q  <= divisor_bs_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.bs_valid    = valid_q;
  assign bus.done        = done_q;
  assign bus.dividend_bs = dividend_bs_q;
  assign bus.divisor_bs  = divisor_bs_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cordiv_sng.sv
// Directed bench for cordiv_sng: a WIDTH=4 instance for exact stream
// patterns, mid-run disturbances and back-to-back runs, and a WIDTH=8
// instance for ones-count sweeps in both random-source modes.
module tb_cordiv_sng;

  logic       clk;
  logic       rst;
  logic [1:0] dbg4;
  logic [1:0] dbg8;

  int checks = 0;
  int errors = 0;

  cordiv_sng_if #(.WIDTH(4)) if4 ();
  cordiv_sng_if #(.WIDTH(8)) if8 ();

  cordiv_sng #(.WIDTH(4), .SEED(1)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4), .dbg_state_o(dbg4)
  );
  cordiv_sng #(.WIDTH(8), .SEED(1)) u_dut8 (
    .clk(clk), .rst(rst), .bus(if8), .dbg_state_o(dbg8)
  );

  // Clock and global time bound
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // WIDTH=8 directed table: mode, operands and hand-computed ones counts.
  bit         m8 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] a8 [7] = '{8'd0, 8'd1,   8'd128, 8'd255, 8'd255, 8'd100, 8'd0};
  logic [7:0] b8 [7] = '{8'd1, 8'd128, 8'd255, 8'd255, 8'd0,   8'd255, 8'd100};
  int         ea [7] = '{0, 1,   128, 255, 255, 100, 0};
  int         eb [7] = '{1, 128, 255, 255, 0,   255, 100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 run in mode 0. evt=1: at bit 7 change dividend_bin and
  // pulse start; evt=2: assert rst for one edge at bit 10.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input int evt,
                      output logic [15:0] va, output logic [15:0] vb,
                      output int nvalid, output int ndone, output int done_idx,
                      output int busy_cyc, output logic timed_out);
    va = '0; vb = '0; nvalid = 0; ndone = 0; done_idx = -1; busy_cyc = 0;
    timed_out = 1'b1;
    if4.dividend_bin = a;
    if4.divisor_bin  = b;
    if4.mode         = 1'b0;
    if4.start        = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if4.start = 1'b0;
      rst       = 1'b0;
      if (!if4.busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cyc++;
      if (if4.bs_valid) begin
        if (nvalid < 16) begin
          va[nvalid] = if4.dividend_bs;
          vb[nvalid] = if4.divisor_bs;
        end
        if (if4.done) begin
          ndone++;
          done_idx = nvalid;
        end
        if (evt == 1 && nvalid == 7) begin
          if4.dividend_bin = 4'hF;
          if4.start        = 1'b1;
        end
        if (evt == 2 && nvalid == 10) rst = 1'b1;
        nvalid++;
      end
      @(negedge clk);
    end
  endtask

  // One WIDTH=8 run: ones counts and correlation violations.
  task automatic run8(input bit m, input logic [7:0] a, input logic [7:0] b,
                      output int ones_a, output int ones_b, output int nvalid,
                      output int ndone, output int corr_bad, output logic timed_out);
    ones_a = 0; ones_b = 0; nvalid = 0; ndone = 0; corr_bad = 0;
    timed_out = 1'b1;
    if8.dividend_bin = a;
    if8.divisor_bin  = b;
    if8.mode         = m;
    if8.start        = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!if8.busy) begin
        timed_out = 1'b0;
        break;
      end
      if (if8.bs_valid) begin
        nvalid++;
        if (if8.dividend_bs) ones_a++;
        if (if8.divisor_bs) ones_b++;
        if (a <= b && if8.dividend_bs && !if8.divisor_bs) corr_bad++;
        if (if8.done) ndone++;
      end
      @(negedge clk);
    end
  endtask

  // Directed sequence
  initial begin
    logic [15:0] va, vb;
    int nv, nd, di, bc, oa, ob, cb, gaps, bad_runs, run_valid, done_seen;
    logic to;

    rst = 1'b1;
    if4.start = 1'b1; if4.mode = 1'b0; if4.dividend_bin = '0; if4.divisor_bin = '0;
    if8.start = 1'b1; if8.mode = 1'b0; if8.dividend_bin = '0; if8.divisor_bin = '0;

    // Reset held with start high: nothing may start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outputs_%0d", i),
          {if4.busy, if4.bs_valid, if4.done, if4.dividend_bs, if4.divisor_bs,
           if8.busy, if8.bs_valid, if8.done, if8.dividend_bs, if8.divisor_bs,
           dbg4, dbg8}, 32'd0);
    end
    rst = 1'b0;
    if4.start = 1'b0;
    if8.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_after_reset_%0d", i), {if4.busy, if8.busy, dbg4, dbg8}, 32'd0);
    end

    // WIDTH=4 exact pattern 5 / 9.
    run4(4'd5, 4'd9, 0, va, vb, nv, nd, di, bc, to);
    chk("w4_timeout", to, 0);
    chk("w4_dividend_stream", va, 16'h1115);
    chk("w4_divisor_stream", vb, 16'h5557);
    chk("w4_valid_bits", nv, 16);
    chk("w4_done_count", nd, 1);
    chk("w4_done_index", di, 15);
    chk("w4_busy_cycles", bc, 17);

    // Operand change and start pulse mid-run: stream unchanged.
    run4(4'd5, 4'd9, 1, va, vb, nv, nd, di, bc, to);
    chk("mid_timeout", to, 0);
    chk("mid_dividend_stream", va, 16'h1115);
    chk("mid_divisor_stream", vb, 16'h5557);
    chk("mid_done_index", di, 15);
    chk("mid_busy_cycles", bc, 17);

    // The start pulse inside the run must not have queued a second run.
    @(negedge clk);
    chk("mid_no_restart", if4.busy, 0);

    // Reset at bit 10: outputs clear next cycle and no done pulse.
    run4(4'd5, 4'd9, 2, va, vb, nv, nd, di, bc, to);
    chk("rst_exit", to, 0);
    chk("rst_outputs_cleared",
        {if4.busy, if4.bs_valid, if4.done, if4.dividend_bs, if4.divisor_bs, dbg4}, 0);
    chk("rst_partial_bits", nv, 11);
    chk("rst_no_done", nd, 0);
    chk("rst_partial_stream", va[10:0], 11'h115);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if4.done || if4.busy) done_seen++;
    end
    chk("rst_stays_idle", done_seen, 0);

    // Fresh run after the abort starts from bit 0.
    run4(4'd5, 4'd9, 0, va, vb, nv, nd, di, bc, to);
    chk("post_rst_dividend_stream", va, 16'h1115);
    chk("post_rst_valid_bits", nv, 16);
    chk("post_rst_done_index", di, 15);

    // Back-to-back: start held high for three runs.
    if4.dividend_bin = 4'd5;
    if4.divisor_bin  = 4'd9;
    if4.mode         = 1'b0;
    if4.start        = 1'b1;
    nv = 0; nd = 0; gaps = 0; bad_runs = 0; run_valid = 0; to = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 80; c++) begin
      if (if4.bs_valid) begin
        nv++;
        run_valid++;
      end
      if (if4.done) begin
        nd++;
        if (run_valid != 16) bad_runs++;
        run_valid = 0;
        if (nd == 3) if4.start = 1'b0;
      end
      if (!if4.busy) begin
        if (nd == 3) begin
          to = 1'b0;
          break;
        end
        if (nd >= 1) gaps++;
      end
      @(negedge clk);
    end
    if4.start = 1'b0;
    chk("b2b_timeout", to, 0);
    chk("b2b_done_pulses", nd, 3);
    chk("b2b_valid_bits", nv, 48);
    chk("b2b_bits_per_run", bad_runs, 0);
    chk("b2b_idle_gaps", gaps, 2);

    // WIDTH=8 ones-count sweep in both modes.
    for (int i = 0; i < 7; i++) begin
      run8(m8[i], a8[i], b8[i], oa, ob, nv, nd, cb, to);
      chk($sformatf("w8_timeout_%0d", i), to, 0);
      chk($sformatf("w8_ones_dividend_%0d", i), oa, ea[i]);
      chk($sformatf("w8_ones_divisor_%0d", i), ob, eb[i]);
      chk($sformatf("w8_valid_bits_%0d", i), nv, 256);
      chk($sformatf("w8_done_count_%0d", i), nd, 1);
      chk($sformatf("w8_correlation_%0d", i), cb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
